// File: rtl/neo_link_tx.sv
// rtl/neo_link_tx.sv - NEO link single-wire transmitter with ack/retry; optional parity bit via NEO_LINK_PARITY_EN
module neo_link_tx #(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 8,
    parameter int ACK_TIMEOUT  = 4096,
    parameter int MAX_RETRY    = 3,
    localparam int RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data,
    input  logic               send,
    output logic               ready,
    input  logic               ack,
    output logic               serial_out,
    output logic               done,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(ACK_TIMEOUT);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_ACK
    } state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  word, word_nxt;
    logic [CNT_W-1:0]   clk_cnt, clk_cnt_nxt;
    logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               serial_nxt, ready_nxt, done_nxt, fail_nxt;
    logic               bit_end;
    logic [IDX_W-1:0]   idx_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            word        <= '0;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            timer       <= '0;
            retry_count <= '0;
            serial_out  <= 1'b1;
            ready       <= 1'b1;
            done        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_nxt;
            word        <= word_nxt;
            clk_cnt     <= clk_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            timer       <= timer_nxt;
            retry_count <= retry_nxt;
            serial_out  <= serial_nxt;
            ready       <= ready_nxt;
            done        <= done_nxt;
            fail        <= fail_nxt;
        end
    end

    // serial_out is registered, so each branch loads the level of the bit that starts next cycle
    always_comb begin
        state_nxt   = state;
        word_nxt    = word;
        clk_cnt_nxt = clk_cnt;
        bit_idx_nxt = bit_idx;
        timer_nxt   = timer;
        retry_nxt   = retry_count;
        serial_nxt  = serial_out;
        ready_nxt   = ready;
        done_nxt    = 1'b0;
        fail_nxt    = 1'b0;
        bit_end     = (clk_cnt == CNT_LAST);
        idx_inc     = bit_idx + 1'b1;

        case (state)
            S_IDLE: begin
                if (send) begin
                    word_nxt    = data;
                    retry_nxt   = '0;
                    clk_cnt_nxt = '0;
                    serial_nxt  = 1'b0;
                    ready_nxt   = 1'b0;
                    state_nxt   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    serial_nxt  = word[0];
                    state_nxt   = S_DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    if (bit_idx == IDX_LAST) begin
`ifdef NEO_LINK_PARITY_EN
                        serial_nxt = ^word;
                        state_nxt  = S_PARITY;
`else
                        serial_nxt = 1'b1;
                        state_nxt  = S_STOP;
`endif
                    end else begin
                        bit_idx_nxt = idx_inc;
                        serial_nxt  = word[idx_inc];
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    serial_nxt  = 1'b1;
                    state_nxt   = S_STOP;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    timer_nxt   = TMR_W'(1);
                    state_nxt   = S_WAIT_ACK;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_WAIT_ACK: begin
                // ack takes priority over a timeout landing in the same cycle
                if (ack) begin
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end else if (timer == TMR_LAST) begin
                    if (retry_count < RETRY_MAX) begin
                        retry_nxt   = retry_count + 1'b1;
                        clk_cnt_nxt = '0;
                        serial_nxt  = 1'b0;
                        state_nxt   = S_START;
                    end else begin
                        fail_nxt  = 1'b1;
                        ready_nxt = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                serial_nxt = 1'b1;
                ready_nxt  = 1'b1;
                state_nxt  = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_neo_link_tx.sv
// tb/tb_neo_link_tx.sv - directed vector bench for neo_link_tx (DATA_W=8, CLKS_PER_BIT=4, ACK_TIMEOUT=16, MAX_RETRY=2)
module tb_neo_link_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int TO  = 16;
    localparam int MR  = 2;
`ifdef NEO_LINK_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = DW + 2 + P;
    localparam int F     = NBITS * CPB;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       send;
    logic       ready;
    logic       ack;
    logic       serial_out;
    logic       done;
    logic       fail;
    logic [1:0] retry_count;

    neo_link_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB),
        .ACK_TIMEOUT (TO),
        .MAX_RETRY   (MR)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .send       (send),
        .ready      (ready),
        .ack        (ack),
        .serial_out (serial_out),
        .done       (done),
        .fail       (fail),
        .retry_count(retry_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         ack_at;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input logic p, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
        if (P == 1 && b == DW + 1) return p;
        return 1'b1;
    endfunction

    // Walks one whole frame starting on its first cycle; leaves the bench on the first WAIT_ACK cycle
    task automatic check_frame(input logic [7:0] d, input logic p, input int rc,
                               input int ack_cycle, input bit churn);
        for (int c = 0; c < F; c++) begin
            chk("frame_bit", serial_out, exp_bit(d, p, c / CPB));
            chk("frame_ready", ready, 0);
            chk("frame_done", done, 0);
            chk("frame_fail", fail, 0);
            chk("frame_retry", retry_count, rc);
            ack = (c == ack_cycle);
            if (churn) data = 8'($urandom);
            tick();
        end
        ack = 1'b0;
    endtask

    task automatic check_wait(input int n, input int rc);
        for (int c = 0; c < n; c++) begin
            chk("wait_line", serial_out, 1);
            chk("wait_ready", ready, 0);
            chk("wait_done", done, 0);
            chk("wait_fail", fail, 0);
            chk("wait_retry", retry_count, rc);
            tick();
        end
    endtask

    task automatic accept(input logic [7:0] d);
        data = d;
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    task automatic ack_and_check(input int rc);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_ready", ready, 1);
        chk("done_retry", retry_count, rc);
        chk("done_fail", fail, 0);
        chk("done_line", serial_out, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // data, even parity (hand-computed), ack cycle offset into WAIT_ACK
        vecs[0] = '{8'hA5, 1'b0, 5};
        vecs[1] = '{8'h00, 1'b0, 0};
        vecs[2] = '{8'hFF, 1'b0, 15};
        vecs[3] = '{8'h01, 1'b1, 3};
        vecs[4] = '{8'h80, 1'b1, 7};
        vecs[5] = '{8'h3C, 1'b0, 1};
        vecs[6] = '{8'h5A, 1'b0, 14};
        vecs[7] = '{8'h07, 1'b1, 10};

        reset = 1'b1;
        send  = 1'b0;
        ack   = 1'b0;
        data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_line", serial_out, 1);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_retry", retry_count, 0);

        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_ack_done", done, 0);
        chk("idle_ack_ready", ready, 1);

        // Table: one acknowledged frame per vector, ack at varying WAIT_ACK offsets (15 = timeout cycle)
        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].data);
            check_frame(vecs[i].data, vecs[i].par, 0, -1, 1'b0);
            check_wait(vecs[i].ack_at, 0);
            ack_and_check(0);
            tick();
            chk("vec_done_clear", done, 0);
            chk("vec_idle_ready", ready, 1);
            chk("vec_idle_line", serial_out, 1);
            chk("vec_retry_hold", retry_count, 0);
        end

        // Retries exhausted
        accept(8'h3C);
        for (int a = 0; a <= MR; a++) begin
            check_frame(8'h3C, 1'b0, a, -1, 1'b0);
            check_wait(TO, a);
        end
        chk("fail_pulse", fail, 1);
        chk("fail_ready", ready, 1);
        chk("fail_done", done, 0);
        chk("fail_retry", retry_count, MR);
        tick();
        chk("fail_clear", fail, 0);
        chk("fail_retry_hold", retry_count, MR);
        chk("fail_idle_ready", ready, 1);

        // Stray ack during DATA is dropped
        accept(8'h01);
        check_frame(8'h01, 1'b1, 0, 2 * CPB + 1, 1'b0);
        check_wait(TO, 0);
        check_frame(8'h01, 1'b1, 1, -1, 1'b0);
        check_wait(2, 1);
        ack_and_check(1);
        tick();
        chk("stray_done_clear", done, 0);

        // Reset during data bit 3 of a retransmission
        accept(8'h5A);
        check_frame(8'h5A, 1'b0, 0, -1, 1'b0);
        check_wait(TO, 0);
        for (int c = 0; c < 4 * CPB + 1; c++) tick();
        chk("pre_rst_bit3", serial_out, 1);
        chk("pre_rst_retry", retry_count, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_line", serial_out, 1);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_retry", retry_count, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_fail", fail, 0);
        for (int c = 0; c < F + TO + 4; c++) begin
            tick();
            if (done !== 1'b0 || fail !== 1'b0 || ready !== 1'b1 || serial_out !== 1'b1) begin
                chk("post_rst_quiet", {done, fail, ready, serial_out}, 4'b0011);
            end
        end
        chk("post_rst_idle", {done, fail, ready, serial_out}, 4'b0011);

        // Latching with churning data, then back-to-back acceptance on the done cycle
        data = 8'h96;
        send = 1'b1;
        tick();
        check_frame(8'h96, 1'b0, 0, -1, 1'b1);
        data = 8'h4B;
        ack_and_check(0);
        tick();
        send = 1'b0;
        chk("b2b_done_clear", done, 0);
        chk("b2b_ready_low", ready, 0);
        check_frame(8'h4B, 1'b0, 0, -1, 1'b0);
        ack_and_check(0);
        tick();
        chk("b2b_final_clear", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
